// File: rtl/restoring_divider_8_if.sv
// Run/hold handshake and result bus shared by the divider and its switch/key front end.
// Signal names match the multiplier control unit so both can share top-level wiring.
interface restoring_divider_8_if;
    logic       Run;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivByZero;

    modport master (
        output Run, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivByZero
    );

    modport slave (
        input  Run, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivByZero
    );
endinterface

// File: rtl/restoring_divider_8.sv
// 8-bit unsigned restoring divider: one shift-and-trial-subtract per clock for 8 clocks.
// The result is held until the next start; a zero divisor finishes at once with DivByZero set.
module restoring_divider_8 (
    input  logic                         Clk,
    input  logic                         Reset_n,
    restoring_divider_8_if.slave         bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       w_start;

    logic [7:0] r_r;      // partial remainder
    logic [7:0] r_q;      // dividend in, quotient out
    logic [7:0] r_d;      // captured divisor
    logic [2:0] r_cnt;
    logic       r_dbz;

    logic [8:0] w_shifted;
    logic [9:0] w_trial;

    // The extra top bit keeps shifted values of 256 and above from aliasing.
    assign w_shifted = {r_r, r_q[7]};
    assign w_trial   = {1'b0, w_shifted} - {2'b00, r_d};

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Run) begin
                    w_start      = 1'b1;
                    w_state_next = (bus.Divisor == 8'd0) ? S_DONE : S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == 3'd7) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.Run) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: the datapath is a handful of flops, not a memory, so it is cleared by reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_r   <= 8'd0;
            r_q   <= 8'd0;
            r_d   <= 8'd0;
            r_cnt <= 3'd0;
            r_dbz <= 1'b0;
        end else if (w_start) begin
            r_d   <= bus.Divisor;
            r_cnt <= 3'd0;
            if (bus.Divisor == 8'd0) begin
                r_q   <= 8'hFF;
                r_r   <= bus.Dividend;
                r_dbz <= 1'b1;
            end else begin
                r_q   <= bus.Dividend;
                r_r   <= 8'd0;
                r_dbz <= 1'b0;
            end
        end else if (r_state == S_DIV) begin
            r_cnt <= r_cnt + 3'd1;
            if (!w_trial[9]) begin
                r_r <= w_trial[7:0];
                r_q <= {r_q[6:0], 1'b1};
            end else begin
                r_r <= w_shifted[7:0];
                r_q <= {r_q[6:0], 1'b0};
            end
        end
    end

    assign bus.Quotient  = r_q;
    assign bus.Remainder = r_r;
    assign bus.Busy      = (r_state == S_DIV);
    assign bus.Done      = (r_state == S_DONE);
    assign bus.DivByZero = r_dbz;
endmodule
